// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types and constants for the multi-precision add/sub sequencer.
// Holds the FSM state enum, default geometry and the chunk-index width helper.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mp_state_e;

  localparam int SIZE_DEF   = 4;
  localparam int CHUNKS_DEF = 4;

  // A one-chunk operation still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mp_add_slice.sv
// mp_add_slice: combinational SIZE-bit adder slice with carry in and carry out.
// Ports: a_i, b_i (SIZE), cin_i -> sum_o (SIZE), cout_o.
module mp_add_slice #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  input  logic            cin_i,
  output logic [SIZE-1:0] sum_o,
  output logic            cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i}
                         + {1'b0, b_i}
                         + {{SIZE{1'b0}}, cin_i};

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: W-bit add/sub computed one SIZE-bit chunk per cycle, LS chunk first.
// Ports: clk, rst_n, in_* request (valid/ready), out_* result (valid/ready), busy.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter  int SIZE   = SIZE_DEF,
  parameter  int CHUNKS = CHUNKS_DEF,
  localparam int W      = SIZE * CHUNKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);

  localparam int IW = idx_w(CHUNKS);
  localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]                 state_q, state_d;
  logic [IW-1:0]              idx_q;
  logic                       carry_q;
  logic [CHUNKS-1:0][SIZE-1:0] a_q, b_q, sum_q;
  logic                       cout_q, ovf_q, valid_q;

  logic [SIZE-1:0] s_sum;
  logic            s_cout;
  logic            last;

  assign last = (idx_q == LAST);

  mp_add_slice #(.SIZE(SIZE)) u_slice (
    .a_i   (a_q[idx_q]),
    .b_i   (b_q[idx_q]),
    .cin_i (carry_q),
    .sum_o (s_sum),
    .cout_o(s_cout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            // Subtract as A + ~B + ~borrow.
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_cin ^ in_sub;
            idx_q   <= '0;
          end
        end
        S_RUN: begin
          sum_q[idx_q] <= s_sum;
          carry_q      <= s_cout;
          if (last) begin
            cout_q  <= s_cout;
            ovf_q   <= (a_q[CHUNKS-1][SIZE-1] == b_q[CHUNKS-1][SIZE-1])
                    && (s_sum[SIZE-1] != a_q[CHUNKS-1][SIZE-1]);
            valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: scoreboard bench for mp_add_seq (SIZE=4, CHUNKS=4).
// Driver issues requests; a negedge monitor checks results against a full-width model.
module tb_mp_add_seq;

  localparam int SIZE   = 4;
  localparam int CHUNKS = 4;
  localparam int W      = SIZE * CHUNKS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  mp_add_seq #(.SIZE(SIZE), .CHUNKS(CHUNKS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   checks;
  int   failures;
  int   cyc;
  int   last_acc;
  bit   prev_v;
  bit   stream;
  bit   have_last;
  bit   dir_en;
  exp_t dir_exp;

  always @(posedge clk) cyc++;

  // Plain integer arithmetic: unsigned for sum/carry, signed for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint ua, ub, sa, sb, c, r, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = longint'(cin);
    if (sub) begin
      r      = ua - ub - c;
      sr     = sa - sb - c;
      e.cout = (r >= 0);
    end else begin
      r      = ua + ub + c;
      sr     = sa + sb + c;
      e.cout = (r >= (longint'(1) << W));
    end
    e.sum = r[W-1:0];
    e.ovf = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: records accepts into the scoreboard and checks every delivered result.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (lat_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL latency out_valid rose with no accepted request t=%0t", $time);
        end else begin
          chk("latency", longint'(cyc - lat_q.pop_front()), CHUNKS);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL result unexpected sum=%0h required none t=%0t", out_sum, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sum", out_sum, e.sum);
          chk("cout", out_cout, e.cout);
          chk("ovf", out_ovf, e.ovf);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(dir_en ? dir_exp : model(in_a, in_b, in_cin, in_sub));
        lat_q.push_back(cyc + 1);
        if (stream && have_last)
          chk("accept_interval", longint'(cyc + 1 - last_acc), CHUNKS + 2);
        last_acc  = cyc + 1;
        have_last = 1'b1;
      end
      prev_v = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input bit hold);
    bit ok;
    @(posedge clk);
    #1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    dir_en = 1'b0;
  endtask

  task automatic send_dir(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] s, input logic co, input logic ov);
    dir_exp.sum  = s;
    dir_exp.cout = co;
    dir_exp.ovf  = ov;
    dir_en       = 1'b1;
    send(a, b, cin, sub, 1'b0);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sum"}, out_sum, 0);
    chk({tag, "_out_cout"}, out_cout, 0);
    chk({tag, "_out_ovf"}, out_ovf, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    bit ok;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    stream    = 1'b0;
    have_last = 1'b0;
    dir_en    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_idle("in_reset");
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");

    // Directed arithmetic cases.
    send_dir(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
    send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_dir(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    send_dir(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    send_dir(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    drain();

    // Backpressure with a pending request held on the input.
    out_ready = 1'b0;
    send_dir(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_valid_seen", ok, 1);
    @(posedge clk);
    #1;
    in_a     = 16'hABCD;
    in_b     = 16'h1234;
    in_cin   = 1'b1;
    in_sub   = 1'b1;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_sum", out_sum, 16'h3333);
      chk("bp_cout", out_cout, 0);
      chk("bp_ovf", out_ovf, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Reset after the chunk-1 update abandons the operation.
    send_dir(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_q.delete();
    check_idle("mid_run_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    send_dir(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    drain();

    // Streaming: in_valid and out_ready held high, random operands.
    stream    = 1'b1;
    have_last = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b1);
    end
    in_valid = 1'b0;
    drain();
    stream = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
